prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial checker for the 16-bit XNOR Fibonacci PRBS stream produced by the team's LFSR generator (taps 16,15,13,4; seed 16'h0145).
- Self-synchronises to an incoming bit stream, then flywheels a local copy of the sequence and counts bit errors.
- Drops lock when the error density is too high.
- Sits at the receive end of the PRBS link test, downstream of any serialiser or channel.

Parameters:
- LOCK_BITS, 32: consecutive correct predictions required before `locked` asserts.
- ERR_WINDOW, 256: size of the error-density window, in accepted bits.
- ERR_LIMIT, 8: errors within one window that force loss of lock.
- CNT_W, 32: width of the saturating error counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- bit_valid  input  1  qualifies bit_in; exactly one bit is accepted per high cycle.
- bit_in  input  1  received stream bit (the generator's new LSB after each shift).
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle registered pulse per mismatched bit while in LOCKED.
- err_count  output  CNT_W  total LOCKED-state errors; saturates at all-ones.
- period_tick  output  1  one-cycle pulse when the local register returns to the seed while LOCKED.

Behaviour:
- Reset is asynchronous, active-high, clock clk. It sets:
  - L (16-bit local register) = 16'h0145
  - state = FILL
  - fill_cnt = 0, match_cnt = 0, win_cnt = 0, win_err = 0
  - locked = 0, err_pulse = 0, err_count = 0, period_tick = 0
- Prediction: pred = ~(L[15]^L[14]^L[12]^L[3]). This is combinational on L.
- Nothing changes on cycles with bit_valid = 0. err_pulse and period_tick clear to 0 on those cycles.
- FILL:
  - On each valid bit, L <= {L[14:0], bit_in} and fill_cnt increments.
  - After the 16th bit, go to VERIFY with match_cnt = 0.
- VERIFY:
  - On each valid bit, L <= {L[14:0], bit_in}.
  - If bit_in == pred, match_cnt increments. Otherwise match_cnt = 0 and the checker stays in VERIFY, since the shift-in re-seeds L from the stream.
  - When match_cnt reaches LOCK_BITS, go to LOCKED and clear win_cnt and win_err. `locked` rises on that same edge.
- Lockup guard: all-ones is the XNOR lockup state. If L == 16'hFFFF after a shift in VERIFY, hold match_cnt at 0. A constant-1 stream must never lock.
- LOCKED (flywheel):
  - On each valid bit, L <= {L[14:0], pred}. bit_in is never loaded into L.
  - On a mismatch: err_pulse = 1 on that edge, err_count += 1 (saturating, never wraps), win_err += 1.
  - win_cnt counts accepted bits. At ERR_WINDOW, win_cnt and win_err both clear.
  - If win_err reaches ERR_LIMIT inside a window: go to FILL, locked = 0, fill_cnt = 0. err_count is retained.
  - The error that triggers loss of lock is still counted and still pulsed.
  - period_tick = 1 on the edge where the new L == 16'h0145, i.e. once per 65535 accepted bits.
- Simultaneous events:
  - Window rollover and ERR_LIMIT on the same bit: the limit check uses the pre-clear win_err+1, so the checker loses lock.
  - period_tick and err_pulse may assert together.
- Reset mid-operation returns to FILL immediately. No partial state survives.
- Latency: every output is registered, one clk after the accepting edge.

Optional Feature:
- Macro: PRBS_CHK_CLR_EN.
- Defined: adds input err_clr (1-bit). While high it synchronously clears err_count to 0 and has priority over a same-cycle increment. State and lock are unaffected.
- Undefined: no err_clr port. err_count clears only on reset.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS_SEED = 16'h0145
  - tap indices 15, 14, 12, 3
  - function prbs_next_bit(L) returning the XNOR feedback
  - typedef enum chk_state_t {FILL, VERIFY, LOCKED}
- The generator should migrate to the same package.
- No sub-module: one always_ff FSM plus one predict function.

Test Plan:
- Clean lock: drive the generator stream from seed 0x0145 (first bit 1), bit_valid always high. Locked rises exactly 16+32 = 48 valid bits after reset release; err_count stays 0.
- Period: keep the clean stream running. period_tick pulses repeat exactly every 65535 valid bits.
- Single error: flip one bit while LOCKED. Exactly one err_pulse, err_count = 1, locked stays 1, and the next bit is predicted correctly (flywheel, no resync).
- Loss of lock: inject 8 errors within 256 bits. Locked falls on the 8th error edge and err_count = 8. It relocks 48 clean bits later, and err_count is still 8.
- Lockup guard: drive constant 1 for 200 bits. The checker never asserts locked and sits in VERIFY with match_cnt = 0.
- Gaps and reset: toggle bit_valid randomly with a clean stream, and expect the same lock/tick results per accepted bit. Assert reset mid-LOCKED, and all outputs go to 0 asynchronously.
- PRBS_CHK_CLR_EN build: with err_count = 5, assert err_clr together with an error. Count becomes 0 and err_pulse still fires.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the 16-bit XNOR Fibonacci PRBS (taps 16,15,13,4).
// The generator and the checker both use these, so they always agree on the sequence.
package prbs_pkg;

    localparam logic [15:0] PRBS_SEED = 16'h0145;

    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // XNOR feedback; this is also the next stream bit (new LSB after the shift).
    function automatic logic prbs_next_bit(input logic [15:0] l);
        return ~(l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: FILL -> VERIFY -> LOCKED (flywheel) with windowed loss of lock.
// Optional macro PRBS_CHK_CLR_EN adds the err_clr input that synchronously zeroes err_count.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_BITS  = 32,
    parameter int ERR_WINDOW = 256,
    parameter int ERR_LIMIT  = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
`ifdef PRBS_CHK_CLR_EN
    input  logic             err_clr,
`endif
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             period_tick,
    output logic [1:0]       dbg_state,
    output logic [15:0]      dbg_match_cnt
);

    localparam int MW = $clog2(LOCK_BITS + 1);
    localparam int WW = $clog2(ERR_WINDOW + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    chk_state_t       state_q;
    logic [15:0]      l_q;
    logic [3:0]       fill_cnt_q;
    logic [MW-1:0]    match_cnt_q;
    logic [WW-1:0]    win_cnt_q;
    logic [EW-1:0]    win_err_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             period_tick_q;
    logic [CNT_W-1:0] err_count_q;

    logic             pred;
    logic             mismatch;
    logic [15:0]      l_stream_d;
    logic [15:0]      l_fly_d;
    logic [MW-1:0]    match_cnt_d;
    logic [WW-1:0]    win_cnt_d;
    logic [EW-1:0]    win_err_d;
    logic [CNT_W-1:0] err_count_d;
    logic             win_roll;

    assign pred        = prbs_next_bit(l_q);
    assign mismatch    = bit_in ^ pred;
    assign l_stream_d  = {l_q[14:0], bit_in};
    assign l_fly_d     = {l_q[14:0], pred};
    assign match_cnt_d = match_cnt_q + 1'b1;
    assign win_cnt_d   = win_cnt_q + 1'b1;
    assign win_err_d   = win_err_q + 1'b1;
    assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
    assign win_roll    = (win_cnt_d == WW'(ERR_WINDOW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            l_q           <= PRBS_SEED;
            fill_cnt_q    <= '0;
            match_cnt_q   <= '0;
            win_cnt_q     <= '0;
            win_err_q     <= '0;
            locked_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            period_tick_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            err_pulse_q   <= 1'b0;
            period_tick_q <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    FILL: begin
                        l_q        <= l_stream_d;
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == 4'd15) begin
                            state_q     <= VERIFY;
                            match_cnt_q <= '0;
                        end
                    end
                    VERIFY: begin
                        l_q <= l_stream_d;
                        // All-ones predicts itself forever, so it can never count as a match.
                        if (mismatch || (l_stream_d == 16'hFFFF)) begin
                            match_cnt_q <= '0;
                        end else if (match_cnt_d == MW'(LOCK_BITS)) begin
                            state_q     <= LOCKED;
                            locked_q    <= 1'b1;
                            match_cnt_q <= '0;
                            win_cnt_q   <= '0;
                            win_err_q   <= '0;
                        end else begin
                            match_cnt_q <= match_cnt_d;
                        end
                    end
                    LOCKED: begin
                        l_q           <= l_fly_d;
                        period_tick_q <= (l_fly_d == PRBS_SEED);
                        win_cnt_q     <= win_roll ? '0 : win_cnt_d;
                        if (mismatch) begin
                            err_pulse_q <= 1'b1;
                            err_count_q <= err_count_d;
                            // Limit is judged on the pre-clear count, so it wins over rollover.
                            if (win_err_d == EW'(ERR_LIMIT)) begin
                                state_q    <= FILL;
                                locked_q   <= 1'b0;
                                fill_cnt_q <= '0;
                                win_err_q  <= '0;
                            end else begin
                                win_err_q <= win_roll ? '0 : win_err_d;
                            end
                        end else if (win_roll) begin
                            win_err_q <= '0;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
`ifdef PRBS_CHK_CLR_EN
            if (err_clr) begin
                err_count_q <= '0;
            end
`endif
        end
    end

    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign period_tick   = period_tick_q;
    assign dbg_state     = state_q;
    assign dbg_match_cnt = 16'(match_cnt_q);

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker: lock, period, errors, window, lockup guard, gaps, reset.
// Build with +define+PRBS_CHK_CLR_EN to also exercise err_clr.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_valid;
    logic        bit_in;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic        period_tick;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_match_cnt;
`ifdef PRBS_CHK_CLR_EN
    logic        err_clr;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [15:0] g;
    logic [31:0] exp_q[$];

    prbs_checker dut (
        .clk          (clk),
        .reset        (reset),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
`ifdef PRBS_CHK_CLR_EN
        .err_clr      (err_clr),
`endif
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period_tick  (period_tick),
        .dbg_state    (dbg_state),
        .dbg_match_cnt(dbg_match_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // drivers
    task automatic drive(input logic v, input logic b);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    // Reference generator: XNOR of taps 16,15,13,4 becomes the new LSB.
    task automatic gen_bit(output logic b);
        b = ~(g[15] ^ g[14] ^ g[12] ^ g[3]);
        g = {g[14:0], b};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        g     = 16'h0145;
    endtask

    task automatic lock_clean(output int rise);
        logic b;
        rise = 0;
        for (int i = 1; i <= 48; i++) begin
            gen_bit(b);
            drive(1'b1, b);
            if (locked && rise == 0) rise = i;
        end
    endtask

    // tests
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got locked=%b pulse=%b tick=%b expected 0 0 0", locked, err_pulse, period_tick);
        end
        checks++;
        if (err_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", err_count);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        @(negedge clk);
        reset = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic test_clean_lock_and_period();
        logic b;
        int rise, first_tick, ticks, pulses;
        do_reset();
        rise = 0; first_tick = 0; ticks = 0; pulses = 0;
        for (int n = 1; n <= 65540; n++) begin
            gen_bit(b);
            drive(1'b1, b);
            if (locked && rise == 0) rise = n;
            if (period_tick) begin
                ticks++;
                if (first_tick == 0) first_tick = n;
            end
            if (err_pulse) pulses++;
        end
        checks++;
        if (rise !== 48) begin
            errors++;
            $display("FAIL clean_lock_rise: got bit %0d expected 48", rise);
        end
        checks++;
        if (first_tick !== 65535 || ticks !== 1) begin
            errors++;
            $display("FAIL period_tick: got first=%0d count=%0d expected 65535 1", first_tick, ticks);
        end
        checks++;
        if (err_count !== 32'd0 || pulses !== 0) begin
            errors++;
            $display("FAIL clean_errors: got count=%0d pulses=%0d expected 0 0", err_count, pulses);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL clean_still_locked: got %b expected 1", locked);
        end
    endtask

    task automatic test_single_error();
        logic b;
        int rise;
        do_reset();
        lock_clean(rise);
        checks++;
        if (rise !== 48) begin
            errors++;
            $display("FAIL single_lock_rise: got %0d expected 48", rise);
        end
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            drive(1'b1, b);
        end
        gen_bit(b);
        drive(1'b1, ~b);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 32'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_error: got pulse=%b count=%0d locked=%b expected 1 1 1", err_pulse, err_count, locked);
        end
        gen_bit(b);
        drive(1'b1, b);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 32'd1) begin
            errors++;
            $display("FAIL single_flywheel: got pulse=%b count=%0d expected 0 1", err_pulse, err_count);
        end
    endtask

    task automatic test_loss_of_lock();
        logic b, e;
        int rise;
        do_reset();
        lock_clean(rise);
        for (int k = 1; k <= 80; k++) begin
            gen_bit(b);
            e = (k % 10 == 0);
            drive(1'b1, b ^ e);
            if (e) begin
                checks++;
                if (err_pulse !== 1'b1 || locked !== (k < 80)) begin
                    errors++;
                    $display("FAIL loss_err_%0d: got pulse=%b locked=%b expected 1 %b", k / 10, err_pulse, locked, k < 80);
                end
            end
        end
        checks++;
        if (err_count !== 32'd8) begin
            errors++;
            $display("FAIL loss_count: got %0d expected 8", err_count);
        end
        lock_clean(rise);
        checks++;
        if (rise !== 48 || err_count !== 32'd8) begin
            errors++;
            $display("FAIL relock: got rise=%0d count=%0d expected 48 8", rise, err_count);
        end
    endtask

    task automatic test_window();
        logic b, e;
        logic [31:0] exp_cnt;
        logic exp_lock;
        int rise;
        do_reset();
        lock_clean(rise);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd15);
        for (int k = 1; k <= 512; k++) begin
            gen_bit(b);
            e = (k <= 7) || (k == 257) || (k >= 506);
            drive(1'b1, b ^ e);
            if (k == 256 || k == 300 || k == 511 || k == 512) begin
                exp_cnt  = exp_q.pop_front();
                exp_lock = (k != 512);
                checks++;
                if (err_count !== exp_cnt || locked !== exp_lock) begin
                    errors++;
                    $display("FAIL window_bit_%0d: got count=%0d locked=%b expected %0d %b", k, err_count, locked, exp_cnt, exp_lock);
                end
            end
        end
    endtask

    task automatic test_lockup();
        int seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b1);
            if (locked) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL lockup_locked: got %0d locked cycles expected 0", seen);
        end
        checks++;
        if (dbg_state !== 2'd1 || dbg_match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lockup_state: got state=%0d match=%0d expected 1 0", dbg_state, dbg_match_cnt);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic b, prev_lock;
        int acc, rise, bad, cyc;
        do_reset();
        acc = 0; rise = 0; bad = 0; cyc = 0;
        while (acc < 100 && cyc < 1000) begin
            cyc++;
            if ($urandom_range(0, 1) == 1) begin
                gen_bit(b);
                drive(1'b1, b);
                acc++;
                if (locked && rise == 0) rise = acc;
            end else begin
                prev_lock = locked;
                drive(1'b0, 1'($urandom_range(0, 1)));
                if (err_pulse || period_tick || locked !== prev_lock) bad++;
            end
        end
        checks++;
        if (rise !== 48 || acc !== 100) begin
            errors++;
            $display("FAIL gaps_lock: got rise=%0d accepted=%0d expected 48 100", rise, acc);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL gaps_idle: got %0d idle-cycle changes expected 0", bad);
        end
        gen_bit(b);
        drive(1'b1, ~b);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 32'd1) begin
            errors++;
            $display("FAIL gaps_error: got pulse=%b count=%0d expected 1 1", err_pulse, err_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 32'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got locked=%b pulse=%b count=%0d tick=%b expected all 0", locked, err_pulse, err_count, period_tick);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef PRBS_CHK_CLR_EN
    task automatic test_err_clr();
        logic b;
        int rise;
        do_reset();
        lock_clean(rise);
        for (int k = 1; k <= 50; k++) begin
            gen_bit(b);
            drive(1'b1, b ^ (k % 10 == 0));
        end
        checks++;
        if (err_count !== 32'd5) begin
            errors++;
            $display("FAIL clr_precount: got %0d expected 5", err_count);
        end
        gen_bit(b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = ~b;
        err_clr   = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err_count !== 32'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL err_clr: got count=%0d pulse=%b locked=%b expected 0 1 1", err_count, err_pulse, locked);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        g         = 16'h0145;
`ifdef PRBS_CHK_CLR_EN
        err_clr   = 1'b0;
`endif
        test_reset();
        test_clean_lock_and_period();
        test_single_error();
        test_loss_of_lock();
        test_window();
        test_lockup();
        test_gaps_and_reset();
`ifdef PRBS_CHK_CLR_EN
        test_err_clr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
